serial_addsub_ctrl: RTL and testbench



---
 rtl/serial_addsub_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full adder/subtractor cell, WIDTH cycles per operation.
// Define SERIAL_ADDSUB_OVERFLOW_EN to enable the signed overflow flag; otherwise overflow is tied to 0.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_sr_q, res_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, mode_q, mode_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             cell_s, cell_co, accept, last;

    full_adder_cum_subtractor u_cell (
        .a       (a_sr_q[0]),
        .b       (b_sr_q[0]),
        .cin     (carry_q),
        .mode    (mode_q),
        .sumdiff (cell_s),
        .cout    (cell_co)
    );

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs, registered from the upcoming state
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Operand latch, serial shift and result capture on the final bit
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (accept) begin
            a_sr_d  = a;
            b_sr_d  = b;
            mode_d  = mode;
            carry_d = mode;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            res_sr_d = {cell_s, res_sr_q[WIDTH-1:1]};
            carry_d  = cell_co;
            cnt_d    = cnt_q + CW'(1);
        end
        if (last) begin
            result_d = {cell_s, res_sr_q[WIDTH-1:1]};
            cout_d   = cell_co;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
            // carry_q is the carry into the MSB while the MSB is being processed
            ovf_d    = carry_q ^ cell_co;
`else
            ovf_d    = 1'b0;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// One-bit adder/subtractor: sumdiff/cout of a + (b ^ mode) + cin.
module full_adder_cum_subtractor (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic sumdiff,
    output logic cout
);
    logic bx;
    assign bx      = b ^ mode;
    assign sumdiff = a ^ bx ^ cin;
    assign cout    = (a & bx) | (cin & (a ^ bx));
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl against an integer-arithmetic reference model.
module tb_serial_addsub_ctrl;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, mode;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, overflow;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    // Reference: plain integer arithmetic, unsigned for cout, signed range for overflow
    function automatic void model(input logic m, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  output logic [W-1:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, full, sres;
        ua   = int'(xa);
        ub   = int'(xb);
        sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb   = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        full = m ? ua - ub : ua + ub;
        sres = m ? sa - sb : sa + sb;
        r    = W'(full);
        c    = m ? (ua >= ub) : (full >= (1 << W));
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
        v    = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
`else
        v    = 1'b0;
`endif
    endfunction

    // Launch one operation from IDLE, scramble inputs, return latency to done (-1 on timeout)
    task automatic run_op(input logic m, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          output int lat, output int nbusy, output int both);
        @(posedge clk); #1;
        start = 1'b1; mode = m; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        lat = -1; nbusy = 0; both = 0;
        for (int k = 1; k <= 4 * W; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (busy && done) both++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if ({result, cout, overflow} !== '0)
            begin errors++; $display("FAIL reset_outputs got %h/%b/%b exp 0/0/0", result, cout, overflow); end
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic m, input logic [W-1:0] xa, input logic [W-1:0] xb);
        logic [W-1:0] er;
        logic ec, ev;
        int lat, nbusy, both;
        model(m, xa, xb, er, ec, ev);
        run_op(m, xa, xb, lat, nbusy, both);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, lat, W + 1); end
        checks++; if (nbusy != W) begin errors++; $display("FAIL %s_busy_cycles got %0d exp %0d", name, nbusy, W); end
        checks++; if (both != 0) begin errors++; $display("FAIL %s_busy_and_done got %0d exp 0", name, both); end
        checks++; if ({result, cout, overflow} !== {er, ec, ev})
            begin errors++; $display("FAIL %s m=%b a=%h b=%h got %h/%b/%b exp %h/%b/%b",
                                     name, m, xa, xb, result, cout, overflow, er, ec, ev); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{8'h35, 8'h7F, 8'hFF, 8'h20, 8'h10, 8'h80};
        logic [W-1:0] vb [6] = '{8'h4A, 8'h01, 8'h01, 8'h10, 8'h20, 8'h01};
        logic         vm [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) check_op("directed", vm[i], va[i], vb[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) check_op("random", 1'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] a1, b1, er, got;
        logic m1, ec, ev;
        int ndone;
        a1 = W'($urandom); b1 = W'($urandom); m1 = 1'($urandom);
        model(m1, a1, b1, er, ec, ev);
        @(posedge clk); #1;
        start = 1'b1; mode = m1; a = a1; b = b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; got = '0;
        for (int k = 1; k <= 3 * W; k++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) got = result;
                ndone++;
            end
            if (k == 3) begin
                start = 1'b1; mode = ~m1; a = ~a1; b = b1 + W'(1);
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignored_done_count got %0d exp 1", ndone); end
        checks++; if (got !== er) begin errors++; $display("FAIL ignored_result got %h exp %h", got, er); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, e1, e2;
        logic m1, c1, v1, c2, v2;
        int t1, t2;
        a1 = W'($urandom); b1 = W'($urandom); m1 = 1'($urandom);
        model(m1, a1, b1, e1, c1, v1);
        model(1'b0, 8'h01, 8'h02, e2, c2, v2);
        @(posedge clk); #1;
        start = 1'b1; mode = m1; a = a1; b = b1;
        @(posedge clk); #1;
        a = 8'h01; b = 8'h02; mode = 1'b0;
        t1 = -1; t2 = -1;
        for (int k = 1; k <= 6 * W; k++) begin
            @(negedge clk);
            if (done && t1 < 0) begin
                t1 = k;
                checks++; if ({result, cout, overflow} !== {e1, c1, v1})
                    begin errors++; $display("FAIL b2b_first got %h/%b/%b exp %h/%b/%b", result, cout, overflow, e1, c1, v1); end
            end else if (t1 > 0 && k == t1 + 1) begin
                start = 1'b0;
                checks++; if (busy !== 1'b1 || result !== e1)
                    begin errors++; $display("FAIL b2b_hold busy=%b result=%h exp busy=1 result=%h", busy, result, e1); end
            end else if (done && t1 > 0) begin
                t2 = k;
                break;
            end
        end
        start = 1'b0;
        checks++; if (t1 != W + 1) begin errors++; $display("FAIL b2b_first_latency got %0d exp %0d", t1, W + 1); end
        checks++; if (t2 - t1 != W + 1 || t2 < 0)
            begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", t2 - t1, W + 1); end
        checks++; if ({result, cout, overflow} !== {e2, c2, v2})
            begin errors++; $display("FAIL b2b_second got %h/%b/%b exp %h/%b/%b", result, cout, overflow, e2, c2, v2); end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_status got %b%b exp 00", busy, done); end
        checks++; if ({result, cout, overflow} !== '0)
            begin errors++; $display("FAIL midrst_outputs got %h/%b/%b exp 0/0/0", result, cout, overflow); end
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_activity got %0d exp 0", ndone); end
        check_op("after_reset", 1'b1, 8'h80, 8'h01);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
